// File: rtl/pic_pc_stack_if.sv
// Bus bundle between the pic core sequencer (master) and the PC/return-stack unit (slave).
// Signal prefixes give direction as seen from the PC/stack unit.
interface pic_pc_stack_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;

  // Sequencer to PC unit
  logic            i_phase_en;
  logic            i_stall;
  logic [2:0]      i_op;
  logic [PC_W-1:0] i_target;

  // PC unit to sequencer / program memory
  logic [PC_W-1:0] o_counter;
  logic [DW-1:0]   o_stack_depth;
  logic            o_stack_overflow;
  logic            o_stack_underflow;
  logic            o_trap;

  modport master (
    output i_phase_en,
    output i_stall,
    output i_op,
    output i_target,
    input  o_counter,
    input  o_stack_depth,
    input  o_stack_overflow,
    input  o_stack_underflow,
    input  o_trap
  );

  modport slave (
    input  i_phase_en,
    input  i_stall,
    input  i_op,
    input  i_target,
    output o_counter,
    output o_stack_depth,
    output o_stack_overflow,
    output o_stack_underflow,
    output o_trap
  );

endinterface

// File: rtl/pic_pc_stack.sv
// Program counter and circular hardware return stack for the pic core.
// The counter advances once per q4 strobe (phase_en) unless stalled, and handles
// INC, GOTO, CALL, RETURN and SKIP. Overflow/underflow flags are sticky until reset.
// Optional feature: define PIC_STACK_TRAP_EN to redirect overflowing CALLs and
// underflowing RETURNs to TRAP_VEC with a one-cycle trap pulse. Without it the
// stack wraps circularly (PIC16 behaviour) and trap is tied low.
module pic_pc_stack #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(4)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pic_pc_stack_if.slave        bus
);

  localparam int unsigned SP_W = $clog2(DEPTH);
  localparam int unsigned DW   = SP_W + 1;

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_GOTO   = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RETURN = 3'd3;
  localparam logic [2:0] OP_SKIP   = 3'd4;

  // Architectural state
  logic [PC_W-1:0] r_counter;
  logic [SP_W-1:0] r_sp;
  logic [DW-1:0]   r_depth;
  logic            r_overflow;
  logic            r_underflow;
  logic            r_trap;

  // Return-address storage; deliberately not reset
  logic [PC_W-1:0] r_stack [DEPTH];

  // Next-state wires
  logic [PC_W-1:0] w_counter_d;
  logic [SP_W-1:0] w_sp_d;
  logic [DW-1:0]   w_depth_d;
  logic            w_overflow_d;
  logic            w_underflow_d;
  logic            w_trap_d;
  logic            w_push;

  logic            w_adv;
  logic            w_full;
  logic            w_empty;
  logic [SP_W-1:0] w_sp_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_skip;
  logic [PC_W-1:0] w_top;

  assign w_adv     = bus.i_phase_en & ~bus.i_stall;
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_empty   = (r_depth == '0);
  // DEPTH is a power of two, so natural wrap of SP_W bits gives the modulo
  assign w_sp_inc  = r_sp + SP_W'(1);
  assign w_sp_dec  = r_sp - SP_W'(1);
  assign w_pc_inc  = r_counter + PC_W'(1);
  assign w_pc_skip = r_counter + PC_W'(2);
  assign w_top     = r_stack[w_sp_dec];

`ifndef PIC_STACK_TRAP_EN
  // TRAP_VEC is only meaningful with the trap feature
  logic w_unused_trap_vec;
  assign w_unused_trap_vec = ^TRAP_VEC;
`endif

  // Next-state decode of the flow-control operation
  always_comb begin
    w_counter_d   = r_counter;
    w_sp_d        = r_sp;
    w_depth_d     = r_depth;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;
    w_trap_d      = 1'b0;
    w_push        = 1'b0;

    if (w_adv) begin
      case (bus.i_op)
        OP_GOTO: begin
          w_counter_d = bus.i_target;
        end

        OP_CALL: begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_sp_d      = w_sp_inc;
            w_depth_d   = r_depth + DW'(1);
            w_counter_d = bus.i_target;
          end else begin
            w_overflow_d = 1'b1;
`ifdef PIC_STACK_TRAP_EN
            w_counter_d  = TRAP_VEC;
            w_trap_d     = 1'b1;
`else
            // Oldest entry is overwritten; depth stays saturated
            w_push       = 1'b1;
            w_sp_d       = w_sp_inc;
            w_counter_d  = bus.i_target;
`endif
          end
        end

        OP_RETURN: begin
          if (!w_empty) begin
            w_sp_d      = w_sp_dec;
            w_depth_d   = r_depth - DW'(1);
            w_counter_d = w_top;
          end else begin
            w_underflow_d = 1'b1;
`ifdef PIC_STACK_TRAP_EN
            w_counter_d   = TRAP_VEC;
            w_trap_d      = 1'b1;
`else
            w_counter_d   = w_pc_inc;
`endif
          end
        end

        OP_SKIP: begin
          w_counter_d = w_pc_skip;
        end

        // OP_INC and the unused encodings 5..7
        default: begin
          w_counter_d = w_pc_inc;
        end
      endcase
    end
  end

  // Counter, pointer, depth and flag registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_counter   <= RESET_VEC;
      r_sp        <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      r_counter   <= w_counter_d;
      r_sp        <= w_sp_d;
      r_depth     <= w_depth_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
      r_trap      <= w_trap_d;
    end
  end

  // Return-address write; reset suppresses a coincident CALL push
  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_stack[r_sp] <= w_pc_inc;
    end
  end

  assign bus.o_counter         = r_counter;
  assign bus.o_stack_depth     = r_depth;
  assign bus.o_stack_overflow  = r_overflow;
  assign bus.o_stack_underflow = r_underflow;
`ifdef PIC_STACK_TRAP_EN
  assign bus.o_trap            = r_trap;
`else
  assign bus.o_trap            = 1'b0;

  // r_trap never sets in this build
  logic w_unused_trap;
  assign w_unused_trap = r_trap;
`endif

endmodule
